// File: rtl/pb_irq_encoder5.sv
// rtl/pb_irq_encoder5.sv - five-source interrupt request encoder for KCPSM3
//
// Purpose:
//   Captures edges on five asynchronous request lines into sticky pending
//   flags. It presents the lowest-numbered pending source to the processor as
//   an interrupt with a 3-bit id, and retires that source on interrupt_ack.
//
// Parameters:
//   INVERT_MASK   - bit i = 1: req_in[i] is active-low; 0: active-high
//
// Ports:
//   clk           in   1  rising-edge clock
//   reset_n       in   1  asynchronous active-low reset
//   req_in        in   5  raw request lines, asynchronous to clk
//   enable        in   5  per-source arm; edges captured only while set
//   interrupt_ack in   1  acknowledge pulse from KCPSM3
//   interrupt     out  1  interrupt request to KCPSM3
//   irq_id        out  3  index (0..4) of the source being serviced
//   pending       out  5  sticky pending flags

module pb_irq_encoder5 #(
  parameter logic [4:0] INVERT_MASK = 5'b01111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] req_in,
  input  logic [4:0] enable,
  input  logic       interrupt_ack,
  output logic       interrupt,
  output logic [2:0] irq_id,
  output logic [4:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [4:0] r_s1;
  logic [4:0] r_s2;
  logic [4:0] r_s2_d;
  logic [4:0] r_pending;
  logic [2:0] r_irq_id;
  logic       r_interrupt;

  logic [4:0] w_act;
  logic [4:0] w_edge;
  logic [4:0] w_clr;
  logic [2:0] w_lowest;
  logic [2:0] w_irq_id_nxt;
  logic       w_any;

  // Normalise polarity so that 1 always means "request active".
  assign w_act  = req_in ^ INVERT_MASK;

  // Rising edge of the synchronised level, gated by the per-source arm.
  assign w_edge = r_s2 & ~r_s2_d & enable;

  assign w_any  = |r_pending;

  // Two-flop synchroniser plus one delayed copy for edge detection. Reset to
  // zero so a source already active at reset release yields exactly one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s2_d <= '0;
    end else begin
      r_s1   <= w_act;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  // Lowest-numbered pending source has the highest priority.
  always_comb begin
    w_lowest = 3'd0;
    if (r_pending[0])      w_lowest = 3'd0;
    else if (r_pending[1]) w_lowest = 3'd1;
    else if (r_pending[2]) w_lowest = 3'd2;
    else if (r_pending[3]) w_lowest = 3'd3;
    else if (r_pending[4]) w_lowest = 3'd4;
  end

  // Next-state logic. Priority is sampled only in IDLE, so an edge arriving
  // during ASSERT waits for the following IDLE. GAP forces one low cycle
  // between back-to-back requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_irq_id_nxt = r_irq_id;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt  = ST_ASSERT;
          w_irq_id_nxt = w_lowest;
        end
      end
      ST_ASSERT: begin
        if (interrupt_ack) begin
          w_state_nxt = ST_GAP;
          w_clr       = 5'b00001 << r_irq_id;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // interrupt is a dedicated flop, so the processor sees a glitch-free level
  // rather than a decode of the state bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_irq_id    <= 3'd0;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_irq_id    <= w_irq_id_nxt;
      r_interrupt <= (w_state_nxt == ST_ASSERT);
    end
  end

  // Set has priority over clear: a new edge on the source being acknowledged
  // in the same cycle leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
    end
  end

  assign interrupt = r_interrupt;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;

endmodule

// File: tb/tb_pb_irq_encoder5.sv
// tb/tb_pb_irq_encoder5.sv - scoreboard testbench for pb_irq_encoder5

module tb_pb_irq_encoder5;

  localparam logic [4:0] IM = 5'b01111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] act;
  logic [4:0] req_in;
  logic [4:0] enable;
  logic       interrupt_ack;
  logic       interrupt;
  logic [2:0] irq_id;
  logic [4:0] pending;

  // act holds the logical (normalised) level of each source.
  assign req_in = IM ^ act;

  pb_irq_encoder5 #(.INVERT_MASK(IM)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_in        (req_in),
    .enable        (enable),
    .interrupt_ack (interrupt_ack),
    .interrupt     (interrupt),
    .irq_id        (irq_id),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] id;
    logic [4:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [4:0] pend);
    exp_t e;
    e.id   = id;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic wait_int(input int bound);
    int k;
    k = 0;
    while (interrupt !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check("wait_interrupt", interrupt, 1);
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  // Monitor: each rising edge of interrupt is one service; compare the
  // presented id and pending flags with the oldest expected entry.
  logic prev_int = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (interrupt === 1'b1 && prev_int !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: irq_id=%0d pending=%b, no expected entry", irq_id, pending);
      end else begin
        e = exp_q.pop_front();
        check("sb_irq_id", irq_id, e.id);
        check("sb_pending", pending, e.pend);
      end
    end
    prev_int = interrupt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] en_r;
    logic [4:0] fire;
    logic [4:0] set;
    logic [4:0] m;
    int         hold;

    act           = '0;
    enable        = 5'h1F;
    interrupt_ack = 1'b0;
    reset_n       = 1'b0;
    repeat (3) tick();
    check("reset_interrupt", interrupt, 0);
    check("reset_irq_id", irq_id, 0);
    check("reset_pending", pending, 0);
    reset_n = 1'b1;
    tick();

    // 1: single active-high source, exact latency
    push(3'd4, 5'b10000);
    act[4] = 1'b1;
    tick(); tick(); tick();
    check("t1_pending", pending, 5'b10000);
    check("t1_int_early", interrupt, 0);
    tick();
    check("t1_int", interrupt, 1);
    check("t1_id", irq_id, 4);
    tick(); tick();
    ack();
    check("t1_ack_int", interrupt, 0);
    check("t1_ack_pend", pending, 0);
    act[4] = 1'b0;
    repeat (4) tick();

    // 2: two active-low sources in one cycle; GAP between services
    push(3'd1, 5'b01010);
    push(3'd3, 5'b01000);
    act[3:0] = 4'b1010;
    wait_int(10);
    check("t2_id1", irq_id, 1);
    ack();
    check("t2_ack_int", interrupt, 0);
    tick();
    check("t2_gap_int", interrupt, 0);
    tick();
    check("t2_reassert", interrupt, 1);
    check("t2_id3", irq_id, 3);
    ack();
    act = '0;
    repeat (4) tick();
    check("t2_idle_pend", pending, 0);

    // 3: higher-priority edge during ASSERT waits
    push(3'd2, 5'b00100);
    push(3'd0, 5'b00001);
    act[2] = 1'b1;
    wait_int(10);
    check("t3_id2", irq_id, 2);
    act[0] = 1'b1;
    repeat (5) tick();
    check("t3_hold_id", irq_id, 2);
    check("t3_hold_int", interrupt, 1);
    check("t3_pend", pending, 5'b00101);
    ack();
    act = '0;
    wait_int(10);
    check("t3_id0", irq_id, 0);
    ack();
    repeat (4) tick();

    // 4: new edge on the same cycle as its own acknowledge
    push(3'd2, 5'b00100);
    push(3'd2, 5'b00100);
    act[2] = 1'b1;
    wait_int(10);
    act[2] = 1'b0;
    repeat (3) tick();
    act[2] = 1'b1;
    tick(); tick();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("t4_pend_kept", pending, 5'b00100);
    check("t4_int_low", interrupt, 0);
    tick();
    check("t4_gap_int", interrupt, 0);
    tick();
    check("t4_reassert", interrupt, 1);
    check("t4_id", irq_id, 2);
    act[2] = 1'b0;
    ack();
    repeat (4) tick();
    check("t4_idle_pend", pending, 0);

    // 5: disabled source ignored; clearing enable keeps a pending flag
    enable = 5'b11101;
    act[1] = 1'b1;
    repeat (3) tick();
    act[1] = 1'b0;
    repeat (4) tick();
    check("t5_dis_pend", pending, 0);
    check("t5_dis_int", interrupt, 0);
    push(3'd0, 5'b00001);
    push(3'd3, 5'b01000);
    act[0] = 1'b1;
    wait_int(10);
    act[3] = 1'b1;
    repeat (4) tick();
    check("t5_pend", pending, 5'b01001);
    enable[3] = 1'b0;
    tick();
    ack();
    act = '0;
    wait_int(10);
    check("t5_id3", irq_id, 3);
    ack();
    enable = 5'h1F;
    repeat (4) tick();

    // 6: asynchronous reset during ASSERT; ack in IDLE ignored
    push(3'd4, 5'b10000);
    act[4] = 1'b1;
    wait_int(10);
    check("t6_id4", irq_id, 4);
    #3;
    reset_n = 1'b0;
    act     = '0;
    #1;
    check("t6_rst_int", interrupt, 0);
    check("t6_rst_pend", pending, 0);
    check("t6_rst_id", irq_id, 0);
    tick();
    reset_n = 1'b1;
    tick();
    ack();
    check("t6_idle_ack_int", interrupt, 0);
    check("t6_idle_ack_pend", pending, 0);
    tick();
    check("t6_idle_ack_int2", interrupt, 0);

    // Random batches: sources fired together are serviced lowest index first
    repeat (25) begin
      en_r = 5'($urandom);
      fire = 5'($urandom);
      set  = fire & en_r;
      enable = en_r;
      for (int i = 0; i < 5; i++) begin
        if (set[i]) begin
          m = 5'h1F << i;
          push(3'(i), set & m);
        end
      end
      act  = fire;
      hold = $urandom_range(2, 4);
      repeat (hold) tick();
      act = '0;
      for (int k = 0; k < $countones(set); k++) begin
        wait_int(20);
        repeat ($urandom_range(0, 3)) tick();
        ack();
        check("rnd_ack_drop", interrupt, 0);
      end
      repeat (4) tick();
      check("rnd_pend_clear", pending, 0);
      check("rnd_int_idle", interrupt, 0);
      enable = 5'h1F;
    end

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
